// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the MM:SS seven-segment scan driver: segment
// patterns, digit indexing and the per-slot state encoding.
package seg_scan_driver_pkg;

    localparam int DIGIT_W = 2;
    typedef logic [DIGIT_W-1:0] digit_t;

    // Digit 2 carries the colon (decimal point); digit 3 is minutes tens.
    localparam digit_t COLON_DIGIT = 2'd2;
    localparam digit_t LEAD_DIGIT  = 2'd3;

    // A digit slot is lit while ACTIVE and dark during the trailing GUARD gap.
    typedef enum logic {
        SLOT_ACTIVE = 1'b0,
        SLOT_GUARD  = 1'b1
    } slot_state_t;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Active-low anode enable for a single digit.
    function automatic logic [3:0] anode_mask(input digit_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Count-word input and display-pin output bundle of the scan driver.
//
// bcd_valid is a one-cycle strobe with no back-pressure: the driver accepts
// every strobe on the cycle it is high, so there is no ready signal. The
// blink_en and blank_lead inputs are levels. slot_state exposes the per-digit
// slot FSM for observation.
interface seg_scan_driver_if;
    import seg_scan_driver_pkg::*;

    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic        blink_en;
    logic        blank_lead;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    slot_state_t slot_state;

    modport master (
        output bcd_in, bcd_valid, blink_en, blank_lead,
        input  an, seg, dp, frame_start, slot_state
    );

    modport slave (
        input  bcd_in, bcd_valid, blink_en, blank_lead,
        output an, seg, dp, frame_start, slot_state
    );

endinterface

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder; values
// 10-15 render as a dash.
module seg_scan_driver_bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup with dash as the fallback for non-decimal codes.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the MM:SS timer count.
// New counts are shadowed and only take effect at frame boundaries so a
// frame never mixes old and new digits.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_PREV = CNT_W'(SCAN_DIV - GUARD - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q;
    digit_t           digit_q;
    slot_state_t      slot_q;
    slot_state_t      slot_d;
    logic [15:0]      pending_q;
    logic [15:0]      disp_q;
    logic [BLK_W-1:0] blink_cnt_q;
    blink_phase_t     blink_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic             fs_q;

    logic             wrap;
    logic             boundary;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic             blank_now;

    assign wrap     = (cnt_q == CNT_LAST);
    // Leaving digit 0 starts a new frame at digit 3.
    assign boundary = wrap && (digit_q == 2'd0);

    // Slot prescaler and digit rotation 3->2->1->0->3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            digit_q <= '0;
        end else if (wrap) begin
            cnt_q   <= '0;
            digit_q <= digit_q - 2'd1;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Slot FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) slot_q <= SLOT_ACTIVE;
        else        slot_q <= slot_d;
    end

    // Slot FSM: go dark for the last GUARD cycles, relight on the next digit.
    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SLOT_ACTIVE: if (cnt_q == GUARD_PREV) slot_d = SLOT_GUARD;
            SLOT_GUARD:  if (wrap)                slot_d = SLOT_ACTIVE;
            default:     slot_d = SLOT_ACTIVE;
        endcase
    end

    // Shadow register; a strobe on the boundary cycle goes straight to disp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            disp_q    <= '0;
        end else begin
            if (bus.bcd_valid) pending_q <= bus.bcd_in;
            if (boundary)      disp_q    <= bus.bcd_valid ? bus.bcd_in : pending_q;
        end
    end

    // Blink half-period frame counter; held in the ON phase while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.blink_en) begin
            blink_cnt_q <= '0;
            blink_q     <= BLINK_ON;
        end else if (boundary) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Digit selection and the three blanking causes.
    always_comb begin
        nibble    = disp_q[{digit_q, 2'b00} +: 4];
        blank_now = (slot_q == SLOT_GUARD)
                 || (bus.blink_en && (blink_q == BLINK_OFF))
                 || ((digit_q == LEAD_DIGIT) && bus.blank_lead && (disp_q[15:12] == 4'h0));
    end

    seg_scan_driver_bcd_to_seg u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    // Registered display pins, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= boundary;
            if (blank_now) begin
                an_q  <= 4'b1111;
                seg_q <= SEG_OFF;
                dp_q  <= 1'b1;
            end else begin
                an_q  <= anode_mask(digit_q);
                seg_q <= dec_seg;
                dp_q  <= (digit_q != COLON_DIGIT);
            end
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;
    assign bus.slot_state  = slot_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Display-side consumer of the kitchen timer's BCD MM:SS count word {min tens, min ones, sec tens, sec ones}.
- Latches each new count into a shadow register and applies it only at frame boundaries, so no digit ever shows a mix of old and new values.
- Time-multiplexes four active-low common-anode seven-segment digits, with a guard gap between digits, optional minutes-tens zero blanking, and whole-display blinking for the expired-timer alarm.
- Sits between the timer count logic and the board's display pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot. Must be at least 4.
- GUARD, 1000: cycles at the end of each slot with all anodes off (anti-ghosting). Must satisfy 1 <= GUARD < SCAN_DIV.
- BLINK_FRAMES, 125: full scan frames per blink half-period.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- bcd_in, input, 16: {bin3, bin2, bin1, bin0} = MM:SS, 4 bits per digit.
- bcd_valid, input, 1: one-cycle strobe; bcd_in holds a new count.
- blink_en, input, 1: level; flash the display.
- blank_lead, input, 1: level; blank digit 3 when its value is 0.
- an, output, 4: active-low anode enables; bit i = digit i (digit 0 = seconds ones, rightmost).
- seg, output, 7: active-low segments {g,f,e,d,c,b,a}.
- dp, output, 1: active-low decimal point.
- frame_start, output, 1: one-cycle pulse when a new frame begins.

Behaviour:
- Reset (rst_n=0 at a clk edge), all state:
  - an=4'b1111, seg=7'b1111111, dp=1, frame_start=0
  - prescaler cnt=0, digit=0
  - pending=16'h0000, disp=16'h0000
  - blink_cnt=0, blink_phase=ON
- Reset mid-frame aborts the scan immediately; no partial state survives.
- Prescaler cnt runs 0..SCAN_DIV-1 and wraps. On wrap, digit advances 3->2->1->0->3. The first frame after reset starts at digit 0, then follows the same order.
- Slot FSM per digit:
  - ACTIVE while cnt < SCAN_DIV-GUARD.
  - GUARD while cnt >= SCAN_DIV-GUARD.
  - Transitions: ACTIVE->GUARD at cnt=SCAN_DIV-GUARD; GUARD->ACTIVE (next digit) on wrap.
- Shadow capture: bcd_valid=1 loads pending<=bcd_in. pending is never shown directly.
- Frame boundary = wrap with digit=0, moving to digit 3. On that edge:
  - disp <= (bcd_valid ? bcd_in : pending); a same-cycle strobe bypasses pending.
  - frame_start pulses on the next cycle.
  - blink_cnt increments. When it reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
- Outputs are registered. an/seg/dp at cycle k reflect cnt/digit/disp at cycle k-1 (latency 1).
- Active digit i: an = ~(1<<i), seg = decode(disp[4i+3:4i]).
  - Decode patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10-15 show a dash: 0111111.
- dp=0 only while digit 2 is active (colon position); otherwise dp=1.
- Blanking. Any of the following forces an=1111, seg=1111111, dp=1:
  - GUARD state;
  - blink_en=1 with blink_phase=OFF;
  - digit 3 active with blank_lead=1 and disp[15:12]=0.
- Leading blank applies to digit 3 only; digit 2 zero is always shown.
- blink_en=0: blink_cnt=0, blink_phase=ON, display steady. Re-asserting blink_en starts with a full ON half-period.
- bcd_valid mid-frame: the current frame finishes with the old disp; the new value appears from the next frame.
- Multiple bcd_valid strobes within one frame: the last one wins.

Decomposition:
- Shared package/header holds:
  - SEG_* 7-bit active-low constants for 0-9 and DASH;
  - DIGIT index width (2);
  - slot-state encodings ACTIVE/GUARD.
- One combinational sub-module, bcd_to_seg (4-bit in, 7-bit active-low out), reused by the timer's other display paths.

Test Plan (bench params SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2):
- Reset, then bcd_valid with bcd_in=16'h1259 before the first boundary:
  - first frame shows all digits as 0 (disp still 0000);
  - next frame: digit0 seg=0010000, digit1 0010010, digit2 0100100 with dp=0, digit3 1111001.
  - Each digit's an is low for 6 cycles, then high for 2.
- Pulse bcd_valid with bcd_in=16'h0030 exactly on the frame-boundary cycle -> the frame just starting shows 0030 (bypass); frame_start=1 on the next cycle only.
- blank_lead=1 with disp=16'h0545 -> an=1111 during the digit-3 slot. With disp=16'h1545 -> digit 3 shows 1111001.
- blink_en=1 with disp=16'h0000 -> 2 frames lit, then 2 frames all-off (an=1111), repeating. Drop blink_en mid-OFF -> display lit in the next ACTIVE slot.
- bcd_in=16'h00A0 -> digit 1 seg=0111111 (dash); other digits show 0.
- Assert rst_n=0 during the digit-2 ACTIVE slot -> the next cycle shows an=1111, seg=1111111, dp=1, and disp is cleared.
